// File: rtl/btb_pkg.sv
// btb_pkg: shared constants, entry layout and FSM encodings for the BTB update path.
package btb_pkg;
  localparam int NUM_SETS = 8;
  localparam int IDX_W    = 3;
  localparam int TAG_W    = 30 - IDX_W;
  localparam int VALID_BIT = 63;
  localparam int TAG_MSB   = 62;
  localparam int TAG_LSB   = 36;
  localparam int TGT_MSB   = 35;
  localparam int TGT_LSB   = 4;
  localparam int FSM_MSB   = 3;
  localparam int FSM_LSB   = 2;
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       fsm;
    logic [1:0]       spare;
  } btb_entry_t;
  typedef enum logic [1:0] {IDLE, LOOKUP, WRITE} btb_state_e;
  function automatic logic [1:0] fsm_next(input logic [1:0] f, input logic taken);
    return taken ? (f == STRONG_T ? f : f + 2'd1) : (f == STRONG_NT ? f : f - 2'd1);
  endfunction
endpackage

// File: rtl/btb_entry_update.sv
// btb_entry_update: computes the rewritten 2-way set, new LRU bit and write enable for one update.
module btb_entry_update
  import btb_pkg::*;
(
  input  logic [127:0]     set_i,
  input  logic             lru_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [31:0]      target_i,
  input  logic             taken_i,
  output logic [127:0]     set_o,
  output logic             lru_o,
  output logic             we_o
);
  btb_entry_t w1, w2, upd, alloc, n1, n2;
  logic hit1, hit2, vic1;
  assign w1    = set_i[127:64];
  assign w2    = set_i[63:0];
  assign hit1  = w1.valid && w1.tag == tag_i;
  assign hit2  = w2.valid && w2.tag == tag_i;
  // an invalid way1 wins first, then an invalid way2, then the LRU choice
  assign vic1  = !w1.valid || (w2.valid && !lru_i);
  assign alloc = '{valid: 1'b1, tag: tag_i, target: target_i, fsm: WEAK_T, spare: 2'b00};
  always_comb begin
    upd        = hit1 ? w1 : w2;
    upd.fsm    = fsm_next(upd.fsm, taken_i);
    upd.target = taken_i ? target_i : upd.target;
    upd.spare  = 2'b00;
    n1         = hit1 ? upd : (!hit2 && vic1) ? alloc : w1;
    n2         = (!hit1 && hit2) ? upd : (!hit1 && !hit2 && !vic1) ? alloc : w2;
    set_o      = {n1, n2};
    we_o       = hit1 || hit2 || taken_i;
    lru_o      = hit1 ? 1'b1 : hit2 ? 1'b0 : taken_i ? vic1 : lru_i;
  end
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: BTB storage with a 3-cycle read-modify-write update path and single-cycle flush.
module btb_update_ctrl
  import btb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  output logic [127:0]     set_data,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [31:0]      upd_pc,
  input  logic [31:0]      upd_target,
  input  logic             upd_taken,
  input  logic             flush,
  output logic             upd_done
);
  btb_state_e state_q, state_d;
  logic [127:0] arr_q [NUM_SETS];
  logic [NUM_SETS-1:0] lru_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0] tgt_q;
  logic [127:0] set_q, new_set;
  logic taken_q, lru_s_q, new_lru, we, accept, done_q, done_d;
  assign set_data = arr_q[rd_index];
  assign upd_done = done_q;
  always_comb begin
    upd_ready = state_q == IDLE && !flush;
    accept    = upd_valid && upd_ready;
    state_d   = flush ? IDLE : state_q == IDLE ? (accept ? LOOKUP : IDLE) : state_q == LOOKUP ? WRITE : IDLE;
    done_d    = state_q == WRITE && !flush;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end
  btb_entry_update u_upd (
    .set_i(set_q), .lru_i(lru_s_q), .tag_i(tag_q), .target_i(tgt_q), .taken_i(taken_q),
    .set_o(new_set), .lru_o(new_lru), .we_o(we)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) arr_q[i] <= '0;
      lru_q   <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      taken_q <= 1'b0;
      set_q   <= '0;
      lru_s_q <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        arr_q[i][VALID_BIT+64] <= 1'b0;
        arr_q[i][VALID_BIT]    <= 1'b0;
      end
      lru_q <= '0;
    end else begin
      if (accept) begin
        idx_q   <= upd_pc[IDX_W+1:2];
        tag_q   <= upd_pc[31:IDX_W+2];
        tgt_q   <= upd_target;
        taken_q <= upd_taken;
      end
      if (state_q == LOOKUP) begin
        set_q   <= arr_q[idx_q];
        lru_s_q <= lru_q[idx_q];
      end
      if (state_q == WRITE && we) begin
        arr_q[idx_q] <= new_set;
        lru_q[idx_q] <= new_lru;
      end
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed self-checking bench for the BTB update controller.
module tb_btb_update_ctrl;
  import btb_pkg::*;
  logic clk = 1'b0, rst = 1'b1, upd_valid = 1'b0, upd_taken = 1'b0, flush = 1'b0;
  logic upd_ready, upd_done;
  logic [IDX_W-1:0] rd_index = '0;
  logic [127:0] set_data;
  logic [31:0] upd_pc = '0, upd_target = '0;
  int tests = 0, fails = 0;
  btb_update_ctrl dut (
    .clk(clk), .rst(rst), .rd_index(rd_index), .set_data(set_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .flush(flush), .upd_done(upd_done)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] ent(input logic [TAG_W-1:0] t, input logic [31:0] g, input logic [1:0] f);
    logic [63:0] e;
    e = '0;
    e[VALID_BIT] = 1'b1;
    e[TAG_MSB:TAG_LSB] = t;
    e[TGT_MSB:TGT_LSB] = g;
    e[FSM_MSB:FSM_LSB] = f;
    return e;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd_chk(input string tag, input logic [IDX_W-1:0] idx, input logic [127:0] exp);
    rd_index = idx;
    #1 chk(tag, set_data, exp);
  endtask
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
    #1 chk("ready_idle", upd_ready, 1);
    @(negedge clk);
    upd_valid = 1'b0;
    chk("done_lookup", upd_done, 0);
    @(negedge clk);
    chk("done_write", upd_done, 0);
    @(negedge clk);
    chk("done_pulse", upd_done, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("reset_ready", upd_ready, 1);
    chk("reset_done", upd_done, 0);
    for (int i = 0; i < NUM_SETS; i++) rd_chk("reset_set", i[IDX_W-1:0], '0);
    // first allocation: pc 0x1010 -> set 4, tag 0x80
    upd(32'h1010, 32'h2000, 1'b1);
    rd_chk("alloc_a", 3'd4, {ent(27'h80, 32'h2000, WEAK_T), 64'h0});
    upd(32'h1010, 32'h3000, 1'b1);
    rd_chk("sat_up1", 3'd4, {ent(27'h80, 32'h3000, STRONG_T), 64'h0});
    upd(32'h1010, 32'h3000, 1'b1);
    rd_chk("sat_up2", 3'd4, {ent(27'h80, 32'h3000, STRONG_T), 64'h0});
    upd(32'h1010, 32'h9999, 1'b0);
    rd_chk("dn1", 3'd4, {ent(27'h80, 32'h3000, WEAK_T), 64'h0});
    upd(32'h1010, 32'h9999, 1'b0);
    rd_chk("dn2", 3'd4, {ent(27'h80, 32'h3000, WEAK_NT), 64'h0});
    upd(32'h1010, 32'h9999, 1'b0);
    rd_chk("dn3", 3'd4, {ent(27'h80, 32'h3000, STRONG_NT), 64'h0});
    upd(32'h1010, 32'h9999, 1'b0);
    rd_chk("sat_dn", 3'd4, {ent(27'h80, 32'h3000, STRONG_NT), 64'h0});
    // B fills way2, A hit, then C and D exercise LRU victim choice
    upd(32'h1030, 32'h4000, 1'b1);
    rd_chk("alloc_b", 3'd4, {ent(27'h80, 32'h3000, STRONG_NT), ent(27'h81, 32'h4000, WEAK_T)});
    upd(32'h1010, 32'h5000, 1'b1);
    rd_chk("hit_a", 3'd4, {ent(27'h80, 32'h5000, WEAK_NT), ent(27'h81, 32'h4000, WEAK_T)});
    upd(32'h1050, 32'h6000, 1'b1);
    rd_chk("alloc_c", 3'd4, {ent(27'h80, 32'h5000, WEAK_NT), ent(27'h82, 32'h6000, WEAK_T)});
    upd(32'h1070, 32'h7000, 1'b1);
    rd_chk("alloc_d", 3'd4, {ent(27'h83, 32'h7000, WEAK_T), ent(27'h82, 32'h6000, WEAK_T)});
    // not-taken misses leave array and LRU alone
    upd(32'h2008, 32'h1234, 1'b0);
    rd_chk("miss_nt_s2", 3'd2, '0);
    upd(32'h1090, 32'h1234, 1'b0);
    rd_chk("miss_nt_s4", 3'd4, {ent(27'h83, 32'h7000, WEAK_T), ent(27'h82, 32'h6000, WEAK_T)});
    upd(32'h10D0, 32'hE000, 1'b1);
    rd_chk("alloc_e", 3'd4, {ent(27'h83, 32'h7000, WEAK_T), ent(27'h86, 32'hE000, WEAK_T)});
    // flush while an allocation sits in LOOKUP
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h10B0; upd_target = 32'h8000; upd_taken = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0; flush = 1'b1;
    #1 chk("flush_ready", upd_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    rd_index = 3'd4;
    #1 chk("flush_valid", {set_data[127], set_data[63]}, 0);
    chk("flush_done", upd_done, 0);
    chk("flush_ready_back", upd_ready, 1);
    @(negedge clk);
    chk("flush_no_done", upd_done, 0);
    rd_chk("flush_no_write", 3'd4, {ent(27'h83, 32'h7000, WEAK_T) & ~64'h8000_0000_0000_0000,
                                    ent(27'h86, 32'hE000, WEAK_T) & ~64'h8000_0000_0000_0000});
    // continuous upd_valid: one acceptance every 3 cycles
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h0024; upd_target = 32'hA000; upd_taken = 1'b1;
    #1 chk("bt_r0", upd_ready, 1);
    @(negedge clk);
    upd_pc = 32'h0044; upd_target = 32'hB000;
    chk("bt_r1", upd_ready, 0);
    @(negedge clk);
    chk("bt_r2", upd_ready, 0);
    @(negedge clk);
    chk("bt_r3", upd_ready, 1);
    chk("bt_done1", upd_done, 1);
    @(negedge clk);
    upd_valid = 1'b0;
    chk("bt_r4", upd_ready, 0);
    chk("bt_nodone", upd_done, 0);
    @(negedge clk);
    chk("bt_r5", upd_ready, 0);
    @(negedge clk);
    chk("bt_done2", upd_done, 1);
    rd_chk("bt_set1", 3'd1, {ent(27'h1, 32'hA000, WEAK_T), ent(27'h2, 32'hB000, WEAK_T)});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
